// File: rtl/npu_mem_pkg.sv
// ----------------------------------------------------------------------------
// npu_mem_pkg
// Shared types and width helpers for the SRAM-buffer write path.
//   wr_arb_state_e : write-arbiter FSM states
//   wr_gnt_e       : which source currently owns the SRAM write port
//   calc_bw        : beat-index width, max(1, clog2(beats per chunk))
//   calc_cw        : chunk-index width, max(1, clog2(max(ifm, flt chunks)))
// ----------------------------------------------------------------------------
package npu_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } wr_arb_state_e;

    typedef enum logic {
        GNT_IFM = 1'b0,
        GNT_FLT = 1'b1
    } wr_gnt_e;

    function automatic int calc_bw(input int beats);
        if (beats <= 1) begin
            return 1;
        end else begin
            return $clog2(beats);
        end
    endfunction

    function automatic int calc_cw(input int ifm_num, input int flt_num);
        int max_num;
        max_num = (ifm_num > flt_num) ? ifm_num : flt_num;
        if (max_num <= 1) begin
            return 1;
        end else begin
            return $clog2(max_num);
        end
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter. Bit 0 is the IFM requester, bit 1 the filter
// requester. When both request, the one that was not granted last wins.
// The pointer advances whenever the owner of the arbiter commits a grant.
//
// Optional build macro: SRAM_WR_ARB_IFM_PRIO_EN
//   defined     -> pointer is pinned to IFM, giving fixed IFM priority
//   not defined -> round-robin
//
// Ports
//   clk_i    in   1  clock
//   rst_ni   in   1  asynchronous reset, active-low (pointer favours IFM)
//   req      in   2  request vector {flt, ifm}
//   advance  in   1  the current grant has been taken; update the pointer
//   gnt      out  2  one-hot grant (all-zero when nothing requests)
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 0: IFM is favoured on a tie, 1: filter is favoured on a tie
    logic prio_r;

    // Grant decode: single requester wins outright, a tie goes to the pointer.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_r ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer update: after a grant, favour the stream that did not win.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_r <= 1'b0;
        end else if (advance) begin
`ifdef SRAM_WR_ARB_IFM_PRIO_EN
            prio_r <= 1'b0;
`else
            prio_r <= gnt[0];
`endif
        end
    end

endmodule

// File: rtl/sram_wr_arbiter.sv
// ----------------------------------------------------------------------------
// sram_wr_arbiter
// Shares the single SRAM-buffer write port between the IFM writer and the
// filter writer. A stream is granted for a whole chunk (BEATS_PER_CHUNK beats
// of sparsemap + nonzero data); each beat is tagged with buffer select, beat
// index and chunk index. Per-stream chunk totals are tracked and done_o
// pulses for one cycle once both streams have delivered every chunk.
//
// Optional build macro: SRAM_WR_ARB_IFM_PRIO_EN (fixed IFM priority instead
// of round-robin between streams).
//
// Ports
//   clk_i, rst_ni                        clock, async active-low reset
//   start_i / busy_o / done_o            job control and status
//   ifm_valid_i/sparsemap_i/data_i       IFM beat source, ifm_ready_o accept
//   flt_valid_i/sparsemap_i/data_i       filter beat source, flt_ready_o accept
//   wr_valid_o / wr_ready_i              SRAM write handshake
//   wr_sel_o                             0 = IFM buffer, 1 = filter buffer
//   wr_sparsemap_o / wr_data_o           muxed beat payload
//   wr_dat_count_o / wr_chunk_count_o    beat index / granted stream's chunk
// ----------------------------------------------------------------------------
module sram_wr_arbiter
    import npu_mem_pkg::*;
#(
    parameter  int BUS_SIZE        = 32,
    parameter  int BEATS_PER_CHUNK = 4,
    parameter  int IFM_CHUNK_NUM   = 8,
    parameter  int FLT_CHUNK_NUM   = 32,
    localparam int BW              = calc_bw(BEATS_PER_CHUNK),
    localparam int CW              = calc_cw(IFM_CHUNK_NUM, FLT_CHUNK_NUM),
    localparam int DW              = BUS_SIZE * 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    output logic                busy_o,
    output logic                done_o,
    input  logic                ifm_valid_i,
    input  logic [BUS_SIZE-1:0] ifm_sparsemap_i,
    input  logic [DW-1:0]       ifm_data_i,
    output logic                ifm_ready_o,
    input  logic                flt_valid_i,
    input  logic [BUS_SIZE-1:0] flt_sparsemap_i,
    input  logic [DW-1:0]       flt_data_i,
    output logic                flt_ready_o,
    output logic                wr_valid_o,
    input  logic                wr_ready_i,
    output logic                wr_sel_o,
    output logic [BUS_SIZE-1:0] wr_sparsemap_o,
    output logic [DW-1:0]       wr_data_o,
    output logic [BW-1:0]       wr_dat_count_o,
    output logic [CW-1:0]       wr_chunk_count_o
);

    // Chunk counters carry one extra bit so that a total equal to a power of
    // two (e.g. 32 chunks with a 5-bit index) is still representable.
    localparam int             TW        = CW + 1;
    localparam logic [TW-1:0]  IFM_TOTAL = TW'(IFM_CHUNK_NUM);
    localparam logic [TW-1:0]  FLT_TOTAL = TW'(FLT_CHUNK_NUM);
    localparam logic [BW-1:0]  LAST_BEAT = BW'(BEATS_PER_CHUNK - 1);

    wr_arb_state_e          state_r;
    wr_gnt_e                gnt_r;
    logic [BW-1:0]          dat_cnt_r;
    logic [TW-1:0]          ifm_cnt_r;
    logic [TW-1:0]          flt_cnt_r;
    logic                   busy_r;
    logic                   done_r;
    logic [BUS_SIZE-1:0]    smap_hold_r;
    logic [DW-1:0]          data_hold_r;

    logic                   ifm_done_s;
    logic                   flt_done_s;
    logic                   all_done_s;
    logic [1:0]             req_s;
    logic [1:0]             rr_gnt_s;
    logic                   arb_adv_s;
    logic                   xfer_s;
    logic                   gnt_flt_s;
    logic                   mux_valid_s;
    logic [BUS_SIZE-1:0]    mux_smap_s;
    logic [DW-1:0]          mux_data_s;
    logic                   fire_s;

    // Completion status and arbitration candidates; a complete stream never requests.
    always_comb begin
        ifm_done_s = (ifm_cnt_r == IFM_TOTAL);
        flt_done_s = (flt_cnt_r == FLT_TOTAL);
        all_done_s = ifm_done_s & flt_done_s;
        req_s      = {flt_valid_i & ~flt_done_s, ifm_valid_i & ~ifm_done_s};
        arb_adv_s  = (state_r == S_ARB) & ~all_done_s & (|req_s);
    end

    // The pointer is recorded when the grant is committed; the next
    // arbitration only happens after that chunk completes, so this is the
    // same as updating it on the last beat.
    rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req     (req_s),
        .advance (arb_adv_s),
        .gnt     (rr_gnt_s)
    );

    // Zero-latency beat mux from the granted source.
    always_comb begin
        xfer_s    = (state_r == S_XFER);
        gnt_flt_s = (gnt_r == GNT_FLT);
        if (gnt_flt_s) begin
            mux_valid_s = flt_valid_i;
            mux_smap_s  = flt_sparsemap_i;
            mux_data_s  = flt_data_i;
        end else begin
            mux_valid_s = ifm_valid_i;
            mux_smap_s  = ifm_sparsemap_i;
            mux_data_s  = ifm_data_i;
        end
        fire_s = xfer_s & mux_valid_s & wr_ready_i;
    end

    // Output drive: live beat during XFER, held payload and idle handshake otherwise.
    always_comb begin
        wr_valid_o     = xfer_s & mux_valid_s;
        ifm_ready_o    = xfer_s & ~gnt_flt_s & wr_ready_i;
        flt_ready_o    = xfer_s &  gnt_flt_s & wr_ready_i;
        wr_sel_o       = gnt_flt_s;
        wr_dat_count_o = dat_cnt_r;
        busy_o         = busy_r;
        done_o         = done_r;
        if (gnt_flt_s) begin
            wr_chunk_count_o = flt_cnt_r[CW-1:0];
        end else begin
            wr_chunk_count_o = ifm_cnt_r[CW-1:0];
        end
        if (xfer_s) begin
            wr_sparsemap_o = mux_smap_s;
            wr_data_o      = mux_data_s;
        end else begin
            wr_sparsemap_o = smap_hold_r;
            wr_data_o      = data_hold_r;
        end
    end

    // Payload hold registers so the write bus keeps its last value outside XFER.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smap_hold_r <= '0;
            data_hold_r <= '0;
        end else if (xfer_s) begin
            smap_hold_r <= mux_smap_s;
            data_hold_r <= mux_data_s;
        end
    end

    // Job FSM: grant a stream per chunk, count beats/chunks, pulse done.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r   <= S_IDLE;
            gnt_r     <= GNT_IFM;
            dat_cnt_r <= '0;
            ifm_cnt_r <= '0;
            flt_cnt_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start_i) begin
                        state_r <= S_ARB;
                        busy_r  <= 1'b1;
                    end
                end
                S_ARB: begin
                    if (all_done_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                    end else if (arb_adv_s) begin
                        state_r   <= S_XFER;
                        gnt_r     <= rr_gnt_s[1] ? GNT_FLT : GNT_IFM;
                        dat_cnt_r <= '0;
                    end
                end
                S_XFER: begin
                    // Bubbles (valid or ready low) leave everything untouched.
                    if (fire_s) begin
                        if (dat_cnt_r == LAST_BEAT) begin
                            dat_cnt_r <= '0;
                            state_r   <= S_ARB;
                            if (gnt_r == GNT_FLT) begin
                                flt_cnt_r <= flt_cnt_r + TW'(1'b1);
                            end else begin
                                ifm_cnt_r <= ifm_cnt_r + TW'(1'b1);
                            end
                        end else begin
                            dat_cnt_r <= dat_cnt_r + BW'(1'b1);
                        end
                    end
                end
                S_DONE: begin
                    // Clear the job so the next start begins from chunk 0.
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    dat_cnt_r <= '0;
                    ifm_cnt_r <= '0;
                    flt_cnt_r <= '0;
                end
                default: begin
                    state_r   <= S_IDLE;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    dat_cnt_r <= '0;
                    ifm_cnt_r <= '0;
                    flt_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_wr_arbiter
// Scoreboard bench: each test pushes the hand-derived beat order of a job,
// two source processes feed beats, and a monitor compares every accepted
// SRAM write beat against the queue head.
// ----------------------------------------------------------------------------
module tb_sram_wr_arbiter;

    localparam int BUS   = 32;
    localparam int DW    = BUS * 8;
    localparam int BEATS = 4;
    localparam int NI    = 8;
    localparam int NF    = 32;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic             ifm_valid_i;
    logic [BUS-1:0]   ifm_sparsemap_i;
    logic [DW-1:0]    ifm_data_i;
    logic             ifm_ready_o;
    logic             flt_valid_i;
    logic [BUS-1:0]   flt_sparsemap_i;
    logic [DW-1:0]    flt_data_i;
    logic             flt_ready_o;
    logic             wr_valid_o;
    logic             wr_ready_i;
    logic             wr_sel_o;
    logic [BUS-1:0]   wr_sparsemap_o;
    logic [DW-1:0]    wr_data_o;
    logic [1:0]       wr_dat_count_o;
    logic [4:0]       wr_chunk_count_o;

    always #5 clk = ~clk;

    sram_wr_arbiter #(
        .BUS_SIZE        (BUS),
        .BEATS_PER_CHUNK (BEATS),
        .IFM_CHUNK_NUM   (NI),
        .FLT_CHUNK_NUM   (NF)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .ifm_valid_i      (ifm_valid_i),
        .ifm_sparsemap_i  (ifm_sparsemap_i),
        .ifm_data_i       (ifm_data_i),
        .ifm_ready_o      (ifm_ready_o),
        .flt_valid_i      (flt_valid_i),
        .flt_sparsemap_i  (flt_sparsemap_i),
        .flt_data_i       (flt_data_i),
        .flt_ready_o      (flt_ready_o),
        .wr_valid_o       (wr_valid_o),
        .wr_ready_i       (wr_ready_i),
        .wr_sel_o         (wr_sel_o),
        .wr_sparsemap_o   (wr_sparsemap_o),
        .wr_data_o        (wr_data_o),
        .wr_dat_count_o   (wr_dat_count_o),
        .wr_chunk_count_o (wr_chunk_count_o)
    );

    typedef struct packed {
        logic           sel;
        logic [1:0]     dat;
        logic [4:0]     chunk;
        logic [1:0]     rdy;    // {flt_ready, ifm_ready}
        logic [BUS-1:0] smap;
        logic [DW-1:0]  data;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp     = 0;
    int    n_err     = 0;
    int    done_cnt  = 0;
    bit    prev_done = 1'b0;
    int    ifm_chunk = 0;
    int    ifm_beat  = 0;
    int    flt_chunk = 0;
    int    flt_beat  = 0;

    function automatic logic [BUS-1:0] smap_f(input bit sel, input int chunk, input int beat);
        return {7'h55, sel, 8'(chunk), 8'h3C, 8'(beat)};
    endfunction

    function automatic logic [DW-1:0] data_f(input logic [BUS-1:0] s);
        return {s, ~s, s ^ 32'hA5A5_A5A5, {s[15:0], s[31:16]},
                s + 32'd1, ~s ^ 32'h0F0F_0F0F, s, ~s};
    endfunction

    function automatic beat_t mk_beat(input bit sel, input int chunk, input int beat);
        beat_t r;
        r.sel   = sel;
        r.dat   = 2'(beat);
        r.chunk = 5'(chunk);
        r.rdy   = sel ? 2'b10 : 2'b01;
        r.smap  = smap_f(sel, chunk, beat);
        r.data  = data_f(r.smap);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic push_chunk(input bit sel, input int chunk);
        for (int b = 0; b < BEATS; b++) exp_q.push_back(mk_beat(sel, chunk, b));
    endtask

    // Expected chunk order when both sources offer data continuously.
    task automatic push_job_both();
`ifdef SRAM_WR_ARB_IFM_PRIO_EN
        for (int i = 0; i < NI; i++) push_chunk(1'b0, i);
        for (int i = 0; i < NF; i++) push_chunk(1'b1, i);
`else
        for (int i = 0; i < NF; i++) begin
            if (i < NI) push_chunk(1'b0, i);
            push_chunk(1'b1, i);
        end
`endif
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        ifm_valid_i = 1'b0;
        flt_valid_i = 1'b0;
        wr_ready_i  = 1'b1;
        exp_q.delete();
        @(negedge clk);
        ifm_chunk = 0; ifm_beat = 0; flt_chunk = 0; flt_beat = 0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    // Returns at the negedge where the requested beat is offered and accepted.
    task automatic wait_beat(input bit sel, input int chunk, input int beat);
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (wr_valid_o && wr_ready_i && wr_sel_o == sel &&
                wr_chunk_count_o == 5'(chunk) && wr_dat_count_o == 2'(beat)) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL wait_beat: got timeout want sel=%0d chunk=%0d beat=%0d", sel, chunk, beat);
        end
    endtask

    task automatic wait_done(input int base);
        bit seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL wait_done: got timeout want done_o pulse");
        end
        @(negedge clk);
        check("done_count", 64'(done_cnt - base), 64'd1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("busy_after_done", 64'(busy_o), 64'd0);
    endtask

    // Beat sources: advance to the next beat after each accepted handshake.
    initial begin
        bit fi;
        bit ff;
        forever begin
            @(negedge clk);
            fi = ifm_valid_i && ifm_ready_o;
            ff = flt_valid_i && flt_ready_o;
            @(posedge clk); #1;
            if (fi) begin
                ifm_beat++;
                if (ifm_beat == BEATS) begin ifm_beat = 0; ifm_chunk++; end
            end
            if (ff) begin
                flt_beat++;
                if (flt_beat == BEATS) begin flt_beat = 0; flt_chunk++; end
            end
            ifm_sparsemap_i = smap_f(1'b0, ifm_chunk, ifm_beat);
            ifm_data_i      = data_f(ifm_sparsemap_i);
            flt_sparsemap_i = smap_f(1'b1, flt_chunk, flt_beat);
            flt_data_i      = data_f(flt_sparsemap_i);
        end
    end

    // Monitor: score every accepted write beat and the shape of done_o.
    initial begin
        beat_t got;
        beat_t want;
        forever begin
            @(negedge clk);
            if (rst_ni) begin
                if (wr_valid_o && wr_ready_i) begin
                    got = {wr_sel_o, wr_dat_count_o, wr_chunk_count_o,
                           flt_ready_o, ifm_ready_o, wr_sparsemap_o, wr_data_o};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL beat_unexpected: got sel=%0d chunk=%0d beat=%0d want none",
                                 got.sel, got.chunk, got.dat);
                    end else begin
                        want = exp_q.pop_front();
                        if (got !== want) begin
                            n_err++;
                            $display("FAIL beat: got sel=%0d beat=%0d chunk=%0d rdy=%b smap=%h want sel=%0d beat=%0d chunk=%0d rdy=%b smap=%h data_eq=%0d",
                                     got.sel, got.dat, got.chunk, got.rdy, got.smap,
                                     want.sel, want.dat, want.chunk, want.rdy, want.smap,
                                     got.data == want.data);
                        end
                    end
                end
                if (done_o) begin
                    done_cnt++;
                    n_cmp++;
                    if (prev_done || !busy_o) begin
                        n_err++;
                        $display("FAIL done_pulse: got prev_done=%0d busy=%0d want 0/1", prev_done, busy_o);
                    end
                end
                prev_done = done_o;
            end else begin
                prev_done = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        rst_ni = 1'b0; start_i = 1'b0; wr_ready_i = 1'b1;
        ifm_valid_i = 1'b0; flt_valid_i = 1'b0;
        ifm_sparsemap_i = '0; ifm_data_i = '0;
        flt_sparsemap_i = '0; flt_data_i = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs",
              64'({busy_o, done_o, ifm_ready_o, flt_ready_o, wr_valid_o, wr_sel_o,
                   wr_dat_count_o, wr_chunk_count_o, |wr_sparsemap_o, |wr_data_o}), 64'd0);
        @(posedge clk); #1 rst_ni = 1'b1;

        // 1: IFM only, then filter once IFM has finished.
        for (int i = 0; i < NI; i++) push_chunk(1'b0, i);
        ifm_valid_i = 1'b1;
        base = done_cnt;
        pulse_start();
        wait_beat(1'b0, NI - 1, BEATS - 1);
        repeat (3) @(negedge clk);
        check("ifm_complete_stall", 64'({busy_o, wr_valid_o, ifm_ready_o, flt_ready_o}), 64'h8);
        for (int i = 0; i < NF; i++) push_chunk(1'b1, i);
        @(posedge clk); #1 flt_valid_i = 1'b1;
        wait_done(base);

        // 2: both valid continuously; a start during the job is ignored.
        do_reset();
        push_job_both();
        ifm_valid_i = 1'b1; flt_valid_i = 1'b1;
        base = done_cnt;
        pulse_start();
        wait_beat(1'b1, 3, 0);
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        check("start_ignored_busy", 64'(busy_o), 64'd1);
        wait_done(base);

        // 3: SRAM back-pressure for 3 cycles at beat 2 of the first chunk.
        do_reset();
        push_job_both();
        ifm_valid_i = 1'b1; flt_valid_i = 1'b1;
        base = done_cnt;
        pulse_start();
        wait_beat(1'b0, 0, 1);
        @(posedge clk); #1 wr_ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_hold", 64'({wr_valid_o, wr_sel_o, wr_dat_count_o, ifm_ready_o, flt_ready_o}),
                  64'b101000);
        end
        @(posedge clk); #1 wr_ready_i = 1'b1;
        wait_done(base);

        // 4: IFM valid drops at beat 1 while filter waits; grant stays on IFM.
        do_reset();
        push_job_both();
        ifm_valid_i = 1'b1; flt_valid_i = 1'b1;
        base = done_cnt;
        pulse_start();
        wait_beat(1'b0, 0, 0);
        @(posedge clk); #1 ifm_valid_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bubble_hold", 64'({wr_valid_o, wr_sel_o, wr_dat_count_o, ifm_ready_o, flt_ready_o}),
                  64'b000110);
        end
        @(posedge clk); #1 ifm_valid_i = 1'b1;
        wait_done(base);

        // 5: reset at beat 2 of IFM chunk 5, then restart from chunk 0.
        do_reset();
        push_job_both();
        ifm_valid_i = 1'b1; flt_valid_i = 1'b1;
        base = done_cnt;
        pulse_start();
        wait_beat(1'b0, 5, 1);
        @(posedge clk); #1;
        check("pre_reset_beat", 64'({wr_valid_o, wr_sel_o, wr_dat_count_o, wr_chunk_count_o}),
              64'({1'b1, 1'b0, 2'd2, 5'd5}));
        rst_ni = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("reset_mid_chunk",
              64'({busy_o, done_o, ifm_ready_o, flt_ready_o, wr_valid_o, wr_sel_o,
                   wr_dat_count_o, wr_chunk_count_o, |wr_sparsemap_o, |wr_data_o}), 64'd0);
        ifm_chunk = 0; ifm_beat = 0; flt_chunk = 0; flt_beat = 0;
        @(posedge clk); #1 rst_ni = 1'b1;
        push_job_both();
        pulse_start();
        wait_done(base);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
